// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter that lets one requester at a time stream a burst of up
// to MAX_BURST words into a FIFO write port. A burst ends after MAX_BURST
// transfers or as soon as the owner drops its valid. A full FIFO only stalls
// the burst and never takes the grant away. Every release passes through at
// least one IDLE cycle, where the next owner is chosen.
`timescale 1ns/1ps

module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          full,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          write_enable,
    output logic                          busy,
    output logic [15:0]                   word_count
);

    localparam int                IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]        LAST_BEAT  = 8'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]  RESET_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [IDX_W-1:0]    r_grantIdx;
    logic [IDX_W-1:0]    r_last;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_burstCount;
    logic [15:0]         r_wordCount;

    logic [IDX_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  w_winnerOneHot;
    logic                w_found;
    logic                w_anyValid;
    logic                w_ownerValid;
    logic                w_writeEnable;
    logic [NUM_REQ-1:0]  w_ready;

    // Round-robin search starting just after the most recently granted index.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_last) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    assign w_winnerOneHot = NUM_REQ'(1) << w_winner;
    assign w_anyValid     = |req_valid;
    assign w_ownerValid   = req_valid[r_grantIdx];
    assign w_writeEnable  = (r_state == BURST) && w_ownerValid && !full;

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: start a burst on any request, end it on the last beat or when the owner drops valid.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_nextState = BURST;
                end
            end
            BURST: begin
                if (!w_ownerValid) begin
                    w_nextState = IDLE;
                end else if (w_writeEnable && (r_burstCount == LAST_BEAT)) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Grant bookkeeping plus the burst and lifetime word counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_grantIdx   <= '0;
            r_last       <= RESET_LAST;
            r_grant      <= '0;
            r_burstCount <= '0;
            r_wordCount  <= '0;
        end else begin
            if ((r_state == IDLE) && w_anyValid) begin
                r_grantIdx   <= w_winner;
                r_last       <= w_winner;
                r_grant      <= w_winnerOneHot;
                r_burstCount <= '0;
            end else if ((r_state == BURST) && (w_nextState == IDLE)) begin
                r_grant <= '0;
            end
            if (w_writeEnable) begin
                r_burstCount <= r_burstCount + 8'd1;
                r_wordCount  <= r_wordCount + 16'd1;
            end
        end
    end

    // Only the owner is told its word was taken, and only when a write happens.
    always_comb begin
        w_ready = '0;
        if (w_writeEnable) begin
            w_ready[r_grantIdx] = 1'b1;
        end
    end

    assign req_ready    = w_ready;
    assign grant        = r_grant;
    assign busy         = (r_state == BURST);
    assign write_enable = w_writeEnable;
    assign write_data   = (r_state == BURST) ? req_data[int'(r_grantIdx) * DATA_WIDTH +: DATA_WIDTH]
                                             : '0;
    assign word_count   = r_wordCount;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Directed scenarios plus randomized traffic checked cycle by cycle against a
// small behavioural model of the arbiter (owner, last winner, beats, words).
`timescale 1ns/1ps

module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int MAX_BURST  = 8;

    logic                          clock = 1'b0;
    logic                          reset_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          full;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          write_enable;
    logic                          busy;
    logic [15:0]                   word_count;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state
    bit mBusy;
    int mOwner;
    int mLast;
    int mCount;
    int mWords;

    fifo_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .grant        (grant),
        .full         (full),
        .write_data   (write_data),
        .write_enable (write_enable),
        .busy         (busy),
        .word_count   (word_count)
    );

    // 100 MHz write clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mBusy  = 1'b0;
        mOwner = 0;
        mLast  = NUM_REQ - 1;
        mCount = 0;
        mWords = 0;
    endtask

    task automatic checkAgainstModel();
        logic [NUM_REQ-1:0]    expGrant;
        logic [NUM_REQ-1:0]    expReady;
        logic                  expWe;
        logic [DATA_WIDTH-1:0] expData;
        expGrant = '0;
        expReady = '0;
        expWe    = 1'b0;
        expData  = '0;
        if (mBusy) begin
            expGrant[mOwner] = 1'b1;
            expData          = req_data[mOwner*DATA_WIDTH +: DATA_WIDTH];
            expWe            = req_valid[mOwner] && !full;
            if (expWe) expReady[mOwner] = 1'b1;
        end
        checkOutput("grant", grant, expGrant);
        checkOutput("busy", busy, mBusy);
        checkOutput("write_enable", write_enable, expWe);
        checkOutput("write_data", write_data, expData);
        checkOutput("req_ready", req_ready, expReady);
        checkOutput("word_count", word_count, mWords);
    endtask

    // Advance the model over one rising edge using the inputs currently driven.
    task automatic modelStep();
        if (!mBusy) begin
            if (req_valid != '0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!mBusy && req_valid[(mLast + k) % NUM_REQ]) begin
                        mOwner = (mLast + k) % NUM_REQ;
                        mBusy  = 1'b1;
                    end
                end
                mLast  = mOwner;
                mCount = 0;
            end
        end else if (!req_valid[mOwner]) begin
            mBusy = 1'b0;
        end else if (!full) begin
            mCount++;
            mWords = (mWords + 1) % 65536;
            if (mCount == MAX_BURST) mBusy = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ*DATA_WIDTH-1:0] data,
                                 input logic fullIn, input bit doCheck);
        @(negedge clock);
        req_valid = valid;
        req_data  = data;
        full      = fullIn;
        #1;
        if (doCheck) checkAgainstModel();
        @(posedge clock);
        modelStep();
    endtask

    // Assert reset in the middle of a low phase and confirm outputs clear without an edge.
    task automatic doReset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_we", write_enable, 0);
        checkOutput("rst_wdata", write_data, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_wcount", word_count, 0);
        modelReset();
        req_valid = '0;
        full      = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [NUM_REQ*DATA_WIDTH-1:0] randomData();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [NUM_REQ-1:0] rv;
        bit seenMax;
        bit wrapped;

        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        full      = 1'b0;
        modelReset();
        doReset();

        // Single requester 2 holding data 420
        applyStimulus(4'b0100, {4{16'd420}}, 1'b0, 1'b1);
        #1 checkOutput("req24_grant", grant, 4'b0100);
        repeat (MAX_BURST) applyStimulus(4'b0100, {4{16'd420}}, 1'b0, 1'b1);
        #1 checkOutput("req24_wcount", word_count, 8);
        checkOutput("req24_idle", grant, 0);
        applyStimulus(4'b0100, {4{16'd420}}, 1'b0, 1'b1);
        #1 checkOutput("req24_regrant", grant, 4'b0100);
        repeat (3) applyStimulus(4'b0100, {4{16'd420}}, 1'b0, 1'b1);

        // All requesters valid: rotation 0,1,2,3,0
        doReset();
        applyStimulus(4'b1111, randomData(), 1'b0, 1'b1);
        for (int b = 0; b < 5; b++) begin
            #1 checkOutput("req25_order", grant, 4'b0001 << (b % NUM_REQ));
            repeat (MAX_BURST) applyStimulus(4'b1111, randomData(), 1'b0, 1'b1);
            if (b < 4) applyStimulus(4'b1111, randomData(), 1'b0, 1'b1);
        end
        #1 checkOutput("req25_wcount", word_count, 40);

        // Requester 1 stalled by full after its third word
        doReset();
        applyStimulus(4'b0010, randomData(), 1'b0, 1'b1);
        repeat (3) applyStimulus(4'b0010, randomData(), 1'b0, 1'b1);
        repeat (5) applyStimulus(4'b0010, randomData(), 1'b1, 1'b1);
        #1 checkOutput("req26_hold", grant, 4'b0010);
        checkOutput("req26_count", word_count, 3);
        repeat (5) applyStimulus(4'b0010, randomData(), 1'b0, 1'b1);
        #1 checkOutput("req26_total", word_count, 8);
        checkOutput("req26_release", busy, 0);

        // Requester 3 drops valid after two words
        doReset();
        applyStimulus(4'b1000, randomData(), 1'b0, 1'b1);
        repeat (2) applyStimulus(4'b1000, randomData(), 1'b0, 1'b1);
        applyStimulus(4'b0000, randomData(), 1'b0, 1'b1);
        #1 checkOutput("req27_idle", busy, 0);
        checkOutput("req27_wcount", word_count, 2);
        applyStimulus(4'b1111, randomData(), 1'b0, 1'b1);
        #1 checkOutput("req27_next", grant, 4'b0001);

        // Reset pulse after the fourth word of a burst
        doReset();
        applyStimulus(4'b0001, randomData(), 1'b0, 1'b1);
        repeat (4) applyStimulus(4'b0001, randomData(), 1'b0, 1'b1);
        doReset();
        applyStimulus(4'b1111, randomData(), 1'b0, 1'b1);
        #1 checkOutput("req28_grant", grant, 4'b0001);
        checkOutput("req28_wcount", word_count, 0);

        // Randomized traffic with stalls and drops
        for (int i = 0; i < 2000; i++) begin
            for (int r = 0; r < NUM_REQ; r++) rv[r] = ($urandom_range(3) != 0);
            applyStimulus(rv, randomData(), ($urandom_range(3) == 0), 1'b1);
        end

        // Stream until word_count wraps past 0xFFFF
        seenMax = 1'b0;
        wrapped = 1'b0;
        for (int i = 0; i < 80000 && !wrapped; i++) begin
            applyStimulus(4'b1111, randomData(), 1'b0, (i % 64) == 0);
            if (mWords == 16'hFFFF) seenMax = 1'b1;
            if (seenMax && mWords == 0) wrapped = 1'b1;
        end
        checkOutput("req29_reached", wrapped, 1);
        #1 checkOutput("req29_wrap", word_count, 16'h0000);
        applyStimulus(4'b1111, randomData(), 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
